decryption: RTL and testbench
=============================

Name: decryption

Overview:
- Inverse-direction companion of the XOR cipher encryption block.
- Reads a ciphertext buffer and a zero-terminated repeating key from two small memories. Writes the XOR-recovered plaintext to a plaintext memory and appends a 0x00 terminator.
- Ciphertext can legitimately contain 0x00 (when a text byte equals its key byte), so it is not zero-terminated. Its length is supplied explicitly at start.

Parameters:
- ADDR_W, 4, address width of the cipher, key and plaintext memories (depth 2^ADDR_W).
- DATA_W, 8, byte width of all data buses.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- cipher_len  in  ADDR_W  number of cipher bytes (0..2^ADDR_W-1); latched on accepted start.
- cipher_data  in  DATA_W  cipher memory read data; combinational read of cipher_addr_ctr.
- key_data  in  DATA_W  key memory read data; combinational read of key_addr_ctr.
- cipher_addr_ctr  out  ADDR_W  cipher memory read address (registered).
- key_addr_ctr  out  ADDR_W  key memory read address (registered).
- plain_w_en  out  1  plaintext memory write strobe.
- plain_addr  out  ADDR_W  plaintext write address.
- plain_data  out  DATA_W  plaintext write data.
- busy  out  1  high in CHECK, XOR and TERM.
- finished  out  1  high in DONE.
- key_error  out  1  high in DONE when the key is empty (key byte 0 is 0x00).

Behaviour:
- Reset (async, any state): state=IDLE; cipher_addr_ctr=0, key_addr_ctr=0, latched length=0; plain_w_en=0, plain_addr=0, plain_data=0; busy=0, finished=0, key_error=0. No write is issued in the reset cycle or the first cycle after reset.
- Registered state and counters. plain_w_en, plain_addr and plain_data are combinational from the current state, counters and read data.
- States:
  - IDLE:
    - Outputs inactive.
    - On start: latch cipher_len, clear both counters and key_error, go to CHECK.
  - CHECK: examines key_data at key address 0.
    - key_data==0: set key_error=1, go to DONE; no writes at all.
    - Else if latched length==0: go to TERM.
    - Else: go to XOR.
  - XOR, key_data!=0:
    - plain_w_en=1, plain_addr=cipher_addr_ctr, plain_data=cipher_data^key_data.
    - Both counters +1.
    - If cipher_addr_ctr==len-1, go to TERM.
  - XOR, key_data==0 (key wrap bubble):
    - plain_w_en=0, key_addr_ctr<=0, cipher_addr_ctr held, stay in XOR.
    - Costs exactly one cycle per wrap.
  - TERM:
    - plain_w_en=1, plain_addr=latched length, plain_data=0.
    - Go to DONE.
  - DONE:
    - finished=1 held; key_error held.
    - start restarts exactly as from IDLE (finished and key_error drop on the next cycle).
- A plaintext byte of 0x00 produced in XOR is written normally; processing does not stop on it.
- key_addr_ctr wraps naturally from 2^ADDR_W-1 to 0 if the key fills the whole memory with no terminator.
- start while busy is ignored; cipher_len changes while busy are ignored.
- Latency for N bytes, K wraps, non-empty key: start cycle → CHECK (1) → N+K XOR cycles → TERM (1) → DONE.
- Every plaintext address 0..len is written exactly once per run, in ascending order.

Test Plan:
- Reset then idle, no start → all outputs 0, no plain_w_en for 20 cycles; rst asserted mid-XOR → next cycle IDLE, all outputs 0.
- Key {0x41,0x42,0x00}, cipher {0x31,0x33,0x30}, len=3, start at cycle 0:
  - Writes (addr:data) 0:0x70 at cycle 2, 1:0x71 at cycle 3.
  - Cycle 4 is a bubble with no write; key_addr_ctr returns to 0.
  - 2:0x71 at cycle 5, 3:0x00 at cycle 6.
  - finished=1 from cycle 7, key_error=0.
- Key {0x41,0x00}, cipher {0x41,0x20}, len=2 → writes 0:0x00, then 1:0x61, then 2:0x00; the 0x00 plaintext does not terminate the run.
- len=0, valid key → single write 0:0x00 in TERM, then DONE.
- Key byte 0 = 0x00, len=5 → no writes, DONE with key_error=1, busy=1 for one cycle only.
- start pulsed during XOR is ignored; start in DONE with new len=1 → second run completes with writes 0 and 1, and finished drops for the run's duration.

Source files
------------

// File: rtl/decryption.sv
// XOR-cipher decryption engine.
// Reads a ciphertext buffer of explicit length and a zero-terminated repeating
// key from two small combinational-read memories. It writes the recovered
// plaintext to a plaintext memory and appends a 0x00 terminator at address len.
// Ciphertext bytes may legitimately be 0x00, so the run length comes from
// cipher_len, which is latched when start is accepted.
module decryption #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] cipher_len,
   input  logic [DATA_W-1:0] cipher_data,
   input  logic [DATA_W-1:0] key_data,
   output logic [ADDR_W-1:0] cipher_addr_ctr,
   output logic [ADDR_W-1:0] key_addr_ctr,
   output logic              plain_w_en,
   output logic [ADDR_W-1:0] plain_addr,
   output logic [DATA_W-1:0] plain_data,
   output logic              busy,
   output logic              finished,
   output logic              key_error
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_XOR   = 3'd2,
      S_TERM  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] cipher_ctr_reg, cipher_ctr_next;
   logic [ADDR_W-1:0] key_ctr_reg, key_ctr_next;
   logic [ADDR_W-1:0] len_reg, len_next;
   logic              key_err_reg, key_err_next;

   // A zero key byte marks the end of the key: at address 0 it means an empty
   // key, and anywhere else it means the key must wrap back to address 0.
   logic              key_end;
   // The current cipher address is the final byte of the run. This is only
   // used in XOR, which is never entered with a zero length.
   logic              last_byte;
   logic [ADDR_W-1:0] len_last;

   assign key_end   = (key_data == '0);
   assign len_last  = len_reg - ADDR_W'(1);
   assign last_byte = (cipher_ctr_reg == len_last);

   assign cipher_addr_ctr = cipher_ctr_reg;
   assign key_addr_ctr    = key_ctr_reg;
   assign key_error       = key_err_reg;

   // State, address counters, latched length and key-error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         cipher_ctr_reg <= '0;
         key_ctr_reg    <= '0;
         len_reg        <= '0;
         key_err_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cipher_ctr_reg <= cipher_ctr_next;
         key_ctr_reg    <= key_ctr_next;
         len_reg        <= len_next;
         key_err_reg    <= key_err_next;
      end
   end

   // Next-state and counter update logic.
   always_comb begin
      state_next      = state_reg;
      cipher_ctr_next = cipher_ctr_reg;
      key_ctr_next    = key_ctr_reg;
      len_next        = len_reg;
      key_err_next    = key_err_reg;

      case (state_reg)
         // IDLE and DONE both accept a new request. A restart from DONE
         // behaves exactly like a start from IDLE.
         S_IDLE, S_DONE: begin
            if (start) begin
               len_next        = cipher_len;
               cipher_ctr_next = '0;
               key_ctr_next    = '0;
               key_err_next    = 1'b0;
               state_next      = S_CHECK;
            end
         end

         // key_addr_ctr is 0 here. An empty key aborts the run without
         // any write. A zero length skips straight to the terminator.
         S_CHECK: begin
            if (key_end) begin
               key_err_next = 1'b1;
               state_next   = S_DONE;
            end else if (len_reg == '0) begin
               state_next = S_TERM;
            end else begin
               state_next = S_XOR;
            end
         end

         // One plaintext byte per cycle. When the key terminator is hit,
         // one bubble cycle rewinds the key address and holds the cipher
         // address.
         S_XOR: begin
            if (key_end) begin
               key_ctr_next = '0;
            end else begin
               cipher_ctr_next = cipher_ctr_reg + ADDR_W'(1);
               key_ctr_next    = key_ctr_reg + ADDR_W'(1);
               if (last_byte) begin
                  state_next = S_TERM;
               end
            end
         end

         S_TERM: begin
            state_next = S_DONE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Plaintext write port and status outputs, decoded from the current state.
   always_comb begin
      plain_w_en = 1'b0;
      plain_addr = '0;
      plain_data = '0;
      busy       = 1'b0;
      finished   = 1'b0;

      case (state_reg)
         S_CHECK: begin
            busy = 1'b1;
         end

         S_XOR: begin
            busy = 1'b1;
            if (!key_end) begin
               plain_w_en = 1'b1;
               plain_addr = cipher_ctr_reg;
               plain_data = cipher_data ^ key_data;
            end
         end

         // The terminator goes right after the last plaintext byte.
         S_TERM: begin
            busy       = 1'b1;
            plain_w_en = 1'b1;
            plain_addr = len_reg;
            plain_data = '0;
         end

         S_DONE: begin
            finished = 1'b1;
         end

         default: begin
            plain_w_en = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_decryption.sv
// Directed scoreboard bench for the decryption engine.
// Stimulus pushes the expected plaintext writes into a queue. Each entry holds
// the cycle, address and data of one write. A monitor on the falling edge pops
// and compares an entry every time the DUT strobes plain_w_en.
`timescale 1ns/1ps
module tb_decryption;

   localparam int AW = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] cipher_len;
   logic [DW-1:0] cipher_data;
   logic [DW-1:0] key_data;
   logic [AW-1:0] cipher_addr_ctr;
   logic [AW-1:0] key_addr_ctr;
   logic          plain_w_en;
   logic [AW-1:0] plain_addr;
   logic [DW-1:0] plain_data;
   logic          busy;
   logic          finished;
   logic          key_error;

   logic [DW-1:0] cipher_mem [16];
   logic [DW-1:0] key_mem    [16];

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp_q[$];

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int t;

   decryption #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .cipher_len      (cipher_len),
      .cipher_data     (cipher_data),
      .key_data        (key_data),
      .cipher_addr_ctr (cipher_addr_ctr),
      .key_addr_ctr    (key_addr_ctr),
      .plain_w_en      (plain_w_en),
      .plain_addr      (plain_addr),
      .plain_data      (plain_data),
      .busy            (busy),
      .finished        (finished),
      .key_error       (key_error)
   );

   // Combinational-read memories.
   assign cipher_data = cipher_mem[cipher_addr_ctr];
   assign key_data    = key_mem[key_addr_ctr];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      e.cyc  = c;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Advance to the falling edge of cycle n.
   task automatic goto(input int n);
      do @(negedge clk); while (cyc < n);
   endtask

   // Drive start for one cycle. t0 is the cycle in which start is high.
   // cipher_len is scrambled afterwards to show that it is latched.
   task automatic do_start(input logic [AW-1:0] len, output int t0);
      @(posedge clk);
      #1;
      start      = 1'b1;
      cipher_len = len;
      t0         = cyc;
      @(posedge clk);
      #1;
      start      = 1'b0;
      cipher_len = ~len;
   endtask

   function automatic logic [31:0] status();
      return {8'd0, plain_w_en, plain_addr, plain_data, busy, finished, key_error,
              cipher_addr_ctr, key_addr_ctr};
   endfunction

   // Write monitor / scoreboard.
   always @(negedge clk) begin
      if (plain_w_en !== 1'b0) begin
         $display("write cycle=%0d addr=%0h data=%02h", cyc, plain_addr, plain_data);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %02h at cycle %0d, required no write",
                     plain_addr, plain_data, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("write_cycle", cyc, e.cyc);
            chk("write_addr", 32'(plain_addr), 32'(e.addr));
            chk("write_data", 32'(plain_data), 32'(e.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      cipher_len = '0;
      for (int i = 0; i < 16; i++) begin
         cipher_mem[i] = '0;
         key_mem[i]    = '0;
      end

      // Reset, then idle without start.
      #2;
      chk("reset_outputs", status(), 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_outputs", status(), 0);
      end

      // Key {41,42,00}, cipher {31,33,30}, len 3: one wrap bubble.
      key_mem[0] = 8'h41; key_mem[1] = 8'h42; key_mem[2] = 8'h00;
      cipher_mem[0] = 8'h31; cipher_mem[1] = 8'h33; cipher_mem[2] = 8'h30;
      do_start(4'd3, t);
      push(t + 2, 4'd0, 8'h70);
      push(t + 3, 4'd1, 8'h71);
      push(t + 5, 4'd2, 8'h71);
      push(t + 6, 4'd3, 8'h00);
      goto(t + 1);
      chk("a_check_busy", 32'(busy), 1);
      chk("a_check_finished", 32'(finished), 0);
      goto(t + 4);
      chk("a_bubble_key_addr", 32'(key_addr_ctr), 2);
      chk("a_bubble_no_write", 32'(plain_w_en), 0);
      goto(t + 5);
      chk("a_wrap_key_addr", 32'(key_addr_ctr), 0);
      chk("a_wrap_cipher_addr", 32'(cipher_addr_ctr), 2);
      goto(t + 7);
      chk("a_finished", 32'(finished), 1);
      chk("a_key_error", 32'(key_error), 0);
      chk("a_done_busy", 32'(busy), 0);
      goto(t + 9);
      chk("a_finished_held", 32'(finished), 1);

      // Key {41,00}, cipher {41,20}, len 2: 0x00 plaintext does not stop the run.
      // A start pulse during XOR, carrying a different length, is ignored.
      key_mem[0] = 8'h41; key_mem[1] = 8'h00;
      cipher_mem[0] = 8'h41; cipher_mem[1] = 8'h20;
      do_start(4'd2, t);
      push(t + 2, 4'd0, 8'h00);
      push(t + 4, 4'd1, 8'h61);
      push(t + 5, 4'd2, 8'h00);
      goto(t + 3);
      start      = 1'b1;
      cipher_len = 4'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      goto(t + 6);
      chk("b_finished", 32'(finished), 1);
      chk("b_key_error", 32'(key_error), 0);

      // Restart from DONE with len 1.
      do_start(4'd1, t);
      push(t + 2, 4'd0, 8'h00);
      push(t + 3, 4'd1, 8'h00);
      goto(t + 1);
      chk("r_finished_drops", 32'(finished), 0);
      chk("r_busy", 32'(busy), 1);
      goto(t + 4);
      chk("r_finished", 32'(finished), 1);

      // len 0 with a valid key: terminator only.
      do_start(4'd0, t);
      push(t + 2, 4'd0, 8'h00);
      goto(t + 2);
      chk("z_term_busy", 32'(busy), 1);
      goto(t + 3);
      chk("z_finished", 32'(finished), 1);

      // Empty key: no writes, busy for one cycle, key_error in DONE.
      key_mem[0] = 8'h00;
      do_start(4'd5, t);
      goto(t + 1);
      chk("e_check_busy", 32'(busy), 1);
      goto(t + 2);
      chk("e_busy_one_cycle", 32'(busy), 0);
      chk("e_finished", 32'(finished), 1);
      chk("e_key_error", 32'(key_error), 1);
      goto(t + 4);
      chk("e_key_error_held", 32'(key_error), 1);

      // Restart clears key_error on the next cycle.
      key_mem[0] = 8'h41;
      do_start(4'd0, t);
      push(t + 2, 4'd0, 8'h00);
      goto(t + 1);
      chk("e_key_error_clears", 32'(key_error), 0);
      goto(t + 3);
      chk("e_restart_finished", 32'(finished), 1);

      // Asynchronous reset in the middle of XOR.
      key_mem[0] = 8'h41; key_mem[1] = 8'h42; key_mem[2] = 8'h00;
      cipher_mem[0] = 8'h31; cipher_mem[1] = 8'h33; cipher_mem[2] = 8'h30;
      do_start(4'd3, t);
      push(t + 2, 4'd0, 8'h70);
      push(t + 3, 4'd1, 8'h71);
      goto(t + 3);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_async_outputs", status(), 0);
      goto(t + 4);
      chk("rst_held_outputs", status(), 0);
      goto(t + 5);
      rst = 1'b0;
      goto(t + 6);
      chk("rst_after_outputs", status(), 0);
      goto(t + 8);
      chk("rst_idle_outputs", status(), 0);

      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
